// File: rtl/locked_reg_pkg.sv
// Shared constants and FSM state type for the locked register access controller.
package locked_reg_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned VIOL_W    = 8;
  localparam logic [NUM_REGS-1:0] LOCK_MASK = 4'b0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = trusted, bit 1 = untrusted.
module rr_arb2 (
  input  logic       Clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_c
);

  logic last_t_q;

  // On a tie the side that did not win last time is chosen
  always_comb begin
    gnt_c = 2'b00;
    if (req == 2'b11) begin
      gnt_c = last_t_q ? 2'b10 : 2'b01;
    end else begin
      gnt_c = req;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      last_t_q <= 1'b0;
    end else if (advance && (|gnt_c)) begin
      last_t_q <= gnt_c[0];
    end
  end

endmodule

// File: rtl/locked_reg_access_ctrl.sv
// Arbitrated register bank with per-register write protection and a sticky lock.
module locked_reg_access_ctrl #(
  parameter int unsigned          DATA_W    = locked_reg_pkg::DATA_W,
  parameter int unsigned          NUM_REGS  = locked_reg_pkg::NUM_REGS,
  parameter logic [NUM_REGS-1:0]  LOCK_MASK = locked_reg_pkg::LOCK_MASK
) (
  input  logic                                Clk,
  input  logic                                resetn,
  input  logic                                Lock,
  input  logic                                t_req,
  input  logic                                t_we,
  input  logic [locked_reg_pkg::ADDR_W-1:0]   t_addr,
  input  logic [DATA_W-1:0]                   t_wdata,
  input  logic                                u_req,
  input  logic                                u_we,
  input  logic [locked_reg_pkg::ADDR_W-1:0]   u_addr,
  input  logic [DATA_W-1:0]                   u_wdata,
  output logic                                t_gnt,
  output logic                                t_done,
  output logic                                t_err,
  output logic                                u_gnt,
  output logic                                u_done,
  output logic                                u_err,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                lock_status,
  output logic [locked_reg_pkg::VIOL_W-1:0]   viol_cnt,
  output logic [NUM_REGS*DATA_W-1:0]          reg_q
);

  import locked_reg_pkg::*;

  localparam int unsigned AW = locked_reg_pkg::ADDR_W;
  localparam int unsigned VW = locked_reg_pkg::VIOL_W;

  state_t            state_q, state_nxt;
  logic [1:0]        arb_gnt_c;
  logic              arb_adv_c;
  logic              commit_c;
  logic              reject_c;

  logic [1:0]        acc_who_q;
  logic              acc_we_q;
  logic [AW-1:0]     acc_addr_q;
  logic [DATA_W-1:0] acc_wdata_q;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [1:0]        gnt_q, gnt_nxt;
  logic [1:0]        done_q, done_nxt;
  logic [1:0]        err_q, err_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic              lock_q;
  logic [VW-1:0]     viol_q;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .resetn  (resetn),
    .req     ({u_req, t_req}),
    .advance (arb_adv_c),
    .gnt_c   (arb_gnt_c)
  );

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and registered response; a write is judged against the lock as seen at commit
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = 2'b00;
    done_nxt  = 2'b00;
    err_nxt   = 2'b00;
    rdata_nxt = rdata_q;
    arb_adv_c = 1'b0;
    commit_c  = 1'b0;
    reject_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt_c) begin
          state_nxt = ACCESS;
          gnt_nxt   = arb_gnt_c;
          arb_adv_c = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        commit_c  = 1'b1;
        done_nxt  = acc_who_q;
        if (acc_we_q) begin
          reject_c  = LOCK_MASK[acc_addr_q] && (acc_who_q[1] || lock_q || Lock);
          err_nxt   = reject_c ? acc_who_q : 2'b00;
          rdata_nxt = '0;
        end else begin
          rdata_nxt = regs_q[acc_addr_q];
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
      lock_q  <= 1'b0;
      viol_q  <= '0;
    end else begin
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
      if (Lock) begin
        lock_q <= 1'b1;
      end
      if (commit_c && reject_c && (viol_q != {VW{1'b1}})) begin
        viol_q <= viol_q + VW'(1);
      end
    end
  end

  // Capture the winning request when leaving IDLE
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      acc_who_q   <= 2'b00;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else if (arb_adv_c) begin
      acc_who_q   <= arb_gnt_c;
      acc_we_q    <= arb_gnt_c[0] ? t_we    : u_we;
      acc_addr_q  <= arb_gnt_c[0] ? t_addr  : u_addr;
      acc_wdata_q <= arb_gnt_c[0] ? t_wdata : u_wdata;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_c && acc_we_q && !reject_c) begin
      regs_q[acc_addr_q] <= acc_wdata_q;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign t_gnt       = gnt_q[0];
  assign u_gnt       = gnt_q[1];
  assign t_done      = done_q[0];
  assign u_done      = done_q[1];
  assign t_err       = err_q[0];
  assign u_err       = err_q[1];
  assign rdata       = rdata_q;
  assign lock_status = lock_q;
  assign viol_cnt    = viol_q;

endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor compares on done.
module tb_locked_reg_access_ctrl;

  localparam logic [3:0] MASK = 4'b0011;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Lock = 1'b0;
  logic        t_req = 1'b0, t_we = 1'b0, u_req = 1'b0, u_we = 1'b0;
  logic [1:0]  t_addr = 2'd0, u_addr = 2'd0;
  logic [15:0] t_wdata = '0, u_wdata = '0;
  logic        t_gnt, t_done, t_err, u_gnt, u_done, u_err, lock_status;
  logic [15:0] rdata;
  logic [7:0]  viol_cnt;
  logic [63:0] reg_q;

  locked_reg_access_ctrl dut (
    .Clk(Clk), .resetn(resetn), .Lock(Lock),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .t_gnt(t_gnt), .t_done(t_done), .t_err(t_err),
    .u_gnt(u_gnt), .u_done(u_done), .u_err(u_err),
    .rdata(rdata), .lock_status(lock_status), .viol_cnt(viol_cnt), .reg_q(reg_q)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          tr;
    bit          err;
    logic [15:0] rdata;
    logic [63:0] regs;
    int unsigned viol;
    bit          lk;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned wait_cnt = 0;

  // Reference state: plain array of register values, sticky lock, saturating counter
  logic [15:0] m_regs [4];
  int unsigned m_viol;
  bit          m_lock;
  bit          m_last_t;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_viol   = 0;
    m_lock   = 1'b0;
    m_last_t = 1'b0;
  endtask

  function automatic bit pick_trusted(input bit rt, input bit ru);
    if (rt && ru) return !m_last_t;
    return rt;
  endfunction

  task automatic model(input bit tr, input bit we, input logic [1:0] a, input logic [15:0] d,
                       input bit lock_now, input int unsigned dcyc);
    exp_t e;
    bit   rej;
    m_last_t = tr;
    e.tr = tr; e.err = 1'b0; e.rdata = '0;
    if (we) begin
      rej = MASK[a] && (!tr || m_lock || lock_now);
      if (rej) begin
        e.err = 1'b1;
        if (m_viol < 255) m_viol++;
      end else begin
        m_regs[a] = d;
      end
    end else begin
      e.rdata = m_regs[a];
    end
    if (lock_now) m_lock = 1'b1;
    e.regs = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    e.viol = m_viol;
    e.lk   = m_lock;
    e.cyc  = dcyc;
    sbq.push_back(e);
  endtask

  // Monitor: compares every done pulse against the oldest expected response
  always @(negedge Clk) begin
    exp_t e;
    if (!resetn) begin
      sbq.delete();
      wait_cnt = 0;
    end else if (t_done || u_done) begin
      wait_cnt = 0;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'({t_done, u_done}), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("done_who", 64'({t_done, u_done}), e.tr ? 64'(2) : 64'(1));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("err", 64'({t_err, u_err}), e.tr ? 64'({e.err, 1'b0}) : 64'({1'b0, e.err}));
        chk("rdata", 64'(rdata), 64'(e.rdata));
        chk("reg_q", reg_q, e.regs);
        chk("viol_cnt", 64'(viol_cnt), 64'(e.viol));
        chk("lock_status", 64'(lock_status), 64'(e.lk));
      end
    end else if (sbq.size() != 0) begin
      wait_cnt++;
      if (wait_cnt > 8) begin
        chk("done_timeout", 64'(wait_cnt), 64'(8));
        sbq.delete();
        wait_cnt = 0;
      end
    end
  end

  task automatic access(input bit tr, input bit we, input logic [1:0] a, input logic [15:0] d,
                        input bit lock_now);
    @(negedge Clk);
    if (tr) begin t_req = 1'b1; t_we = we; t_addr = a; t_wdata = d; end
    else    begin u_req = 1'b1; u_we = we; u_addr = a; u_wdata = d; end
    model(tr, we, a, d, lock_now, cyc + 2);
    @(negedge Clk);
    chk("gnt", 64'({t_gnt, u_gnt}), tr ? 64'(2) : 64'(1));
    if (lock_now) Lock = 1'b1;
    @(negedge Clk);
    Lock = 1'b0;
    chk("gnt_one_cycle", 64'({t_gnt, u_gnt}), 64'(0));
    @(negedge Clk);
    t_req = 1'b0;
    u_req = 1'b0;
  endtask

  task automatic rand_phase(input int n, input bit allow_lock);
    bit          tr, we, lk;
    logic [1:0]  a;
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      tr = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      lk = allow_lock && ($urandom_range(0, 15) == 0);
      access(tr, we, a, d, lk);
    end
  endtask

  // Both sides held high for four back-to-back accesses
  task automatic pair4();
    int unsigned base;
    bit          win [4];
    @(negedge Clk);
    t_req = 1'b1; t_we = 1'b1; t_addr = 2'd3; t_wdata = 16'($urandom);
    u_req = 1'b1; u_we = 1'b0; u_addr = 2'd2;
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      win[i] = pick_trusted(1'b1, 1'b1);
      if (win[i]) model(1'b1, 1'b1, 2'd3, t_wdata, 1'b0, base + 2 + 3 * i);
      else        model(1'b0, 1'b0, 2'd2, 16'h0, 1'b0, base + 2 + 3 * i);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("rr_gnt", 64'({t_gnt, u_gnt}), win[i] ? 64'(2) : 64'(1));
      @(negedge Clk);
      @(negedge Clk);
    end
    t_req = 1'b0;
    u_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg_q"}, reg_q, 64'(0));
    chk({tag, "_viol"}, 64'(viol_cnt), 64'(0));
    chk({tag, "_lock"}, 64'(lock_status), 64'(0));
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    chk({tag, "_ctl"}, 64'({t_gnt, t_done, t_err, u_gnt, u_done, u_err}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge Clk);
    chk_all_zero("post_reset");

    access(1'b1, 1'b1, 2'd0, 16'hA5A5, 1'b0);
    access(1'b0, 1'b1, 2'd1, 16'h1234, 1'b0);
    access(1'b0, 1'b1, 2'd2, 16'h1234, 1'b0);
    access(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
    access(1'b0, 1'b0, 2'd2, 16'h0, 1'b0);

    pair4();
    rand_phase(40, 1'b0);

    access(1'b1, 1'b1, 2'd1, 16'h5555, 1'b0);
    access(1'b1, 1'b1, 2'd1, 16'h6666, 1'b1);

    @(negedge Clk);
    Lock = 1'b1;
    m_lock = 1'b1;
    @(negedge Clk);
    Lock = 1'b0;
    access(1'b1, 1'b1, 2'd0, 16'hFFFF, 1'b0);
    access(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
    repeat (100) @(negedge Clk);
    chk("lock_sticky", 64'(lock_status), 64'(1));

    for (int i = 0; i < 260; i++) access(1'b0, 1'b1, 2'(i % 2), 16'($urandom), 1'b0);

    @(negedge Clk);
    t_req = 1'b1; t_we = 1'b1; t_addr = 2'd2; t_wdata = 16'hBEEF;
    @(negedge Clk);
    chk("abort_gnt", 64'(t_gnt), 64'(1));
    resetn = 1'b0;
    #1;
    chk_all_zero("abort");
    model_reset();
    t_req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("abort_no_done", 64'({t_done, u_done}), 64'(0));
    resetn = 1'b1;
    @(negedge Clk);
    chk("abort_no_done_after", 64'({t_done, u_done}), 64'(0));
    chk_all_zero("abort_release");

    pair4();
    rand_phase(30, 1'b1);

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/locked_reg_access_ctrl.md
LOCKED_REG_ACCESS_CTRL -- requirements
Module: locked_reg_access_ctrl

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DATA_W  16  register/data width
  NUM_REGS  4  registers in bank (address width = 2)
  LOCK_MASK  4'b0011  bit i=1 marks register i as protected
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  Clk  in  1  clock, rising edge
  resetn  in  1  reset, asynchronous, active-low
  Lock  in  1  lock request; sets sticky lock
  t_req / u_req  in  1  trusted / untrusted access request
  t_we / u_we  in  1  1=write, 0=read
  t_addr / u_addr  in  2  register index
  t_wdata / u_wdata  in  DATA_W  write data
  t_gnt / u_gnt  out  1  grant pulse, 1 cycle
  t_done / u_done  out  1  completion pulse, 1 cycle
  t_err / u_err  out  1  rejected write; valid with done
  rdata  out  DATA_W  read data; valid with either done
  lock_status  out  1  sticky lock state
  viol_cnt  out  8  saturating count of rejected writes
  reg_q  out  NUM_REGS*DATA_W  flattened register bank, reg i at [i*DATA_W +: DATA_W]

Function
REQ-003 SHALL sequence accesses with FSM IDLE -> ACCESS -> RESP -> IDLE, one access at a time.
REQ-004 In IDLE, if t_req or u_req is high at a rising edge, FSM SHALL go to ACCESS and latch the winner's we/addr/wdata; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be 2-way round-robin: with a single requester, that requester wins; with both, the one that did not win last wins; last-winner resets to untrusted, so trusted wins the first tie.
REQ-006 In ACCESS, the winner's gnt SHALL be high for exactly one cycle; the access SHALL commit at the ACCESS->RESP edge.
REQ-007 In RESP, the winner's done SHALL be high for exactly one cycle with err and rdata valid; the FSM SHALL then return to IDLE.
REQ-008 Latency SHALL be: req sampled at edge N, gnt in cycle N+1, done and updated reg_q in cycle N+2.
REQ-009 A requester SHALL hold req until done and drop it in the cycle after done; req still high in IDLE SHALL be treated as a new request.
REQ-010 lock_status SHALL set to 1 on any edge where Lock=1, and SHALL clear only on reset; Lock=0 SHALL have no effect.
REQ-011 A write SHALL be rejected (err=1, register unchanged) when (a) the target is protected and the requester is untrusted, or (b) the target is protected and lock_status=1 or Lock=1 at the commit edge. A trusted requester SHALL NOT bypass the lock.
REQ-012 A write to an unprotected register SHALL always succeed (err=0).
REQ-013 Reads SHALL always succeed (err=0); rdata SHALL return the register value at the commit edge; rdata SHALL be 0 after a write.
REQ-014 Each rejected write SHALL increment viol_cnt by 1, saturating at 255.
REQ-015 Addresses SHALL be 2-bit, with no out-of-range case when NUM_REGS=4.

Reset
REQ-016 On resetn low, the following SHALL apply immediately:
  FSM to IDLE
  reg_q, rdata, viol_cnt to 0
  lock_status to 0
  all gnt/done/err to 0
  last-winner to untrusted
REQ-017 Reset during ACCESS or RESP SHALL abandon the access: no commit, no done.

Structure
REQ-018 Package locked_reg_pkg SHALL hold DATA_W, NUM_REGS, the default LOCK_MASK, and the FSM state enum (IDLE, ACCESS, RESP).
REQ-019 The round-robin selection SHALL be in sub-module rr_arb2 (inputs: 2 requests, advance; outputs: one-hot grant), instantiated once.

Verification
REQ-020 Trusted writes 0xA5A5 to reg 0 with lock=0 -> t_gnt in cycle N+1, t_done=1 with t_err=0 in cycle N+2, reg 0=0xA5A5.
REQ-021 Untrusted writes 0x1234 to reg 1 (protected) -> u_err=1, reg 1 unchanged, viol_cnt=1; the same write to reg 2 -> u_err=0, reg 2=0x1234.
REQ-022 Lock pulsed, then trusted writes 0xFFFF to reg 0 -> t_err=1, reg 0 keeps 0xA5A5, lock_status stays 1 after 100 cycles with Lock=0.
REQ-023 t_req and u_req high together for 4 back-to-back accesses -> grants alternate t,u,t,u.
REQ-024 Lock=1 at the commit edge of a trusted write to reg 1 -> rejected (t_err=1); 256+ rejected writes -> viol_cnt stays 255.
REQ-025 resetn low during ACCESS -> no done, all registers and outputs 0, FSM in IDLE, lock_status=0.
